// File: rtl/oldland_fetch.sv
// ---------------------------------------------------------------------------
// oldland_fetch : PC owner and instruction fetch stage feeding oldland_decode
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oldland_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h00000000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] i_addr,
  output logic        i_req,
  input  logic        i_ack,
  input  logic [31:0] i_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  output logic [31:0] instr,
  output logic [31:0] pc_plus_4,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state,     w_state_nxt;
  logic        r_req,       w_req_nxt;
  logic [31:0] r_pc,        w_pc_nxt;
  logic [31:0] r_addr,      w_addr_nxt;
  logic [31:0] r_instr,     w_instr_nxt;
  logic [31:0] r_pc4,       w_pc4_nxt;
  logic        r_valid,     w_valid_nxt;
  logic [31:0] r_skid_data, w_skid_data_nxt;
  logic [31:0] r_skid_pc4,  w_skid_pc4_nxt;

  logic        w_ack;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_pc_inc;

  // An ack only completes a transfer while a request is actually on the bus.
  assign w_ack        = r_req & i_ack;
  assign w_branch_tgt = {branch_pc[31:2], 2'b00};
  assign w_pc_inc     = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_addr_nxt      = r_addr;
    w_instr_nxt     = r_instr;
    w_pc4_nxt       = r_pc4;
    w_valid_nxt     = r_valid;
    w_skid_data_nxt = r_skid_data;
    w_skid_pc4_nxt  = r_skid_pc4;

    if (branch_taken) begin
      w_pc_nxt    = w_branch_tgt;
      w_instr_nxt = BUBBLE_INSTR;
      w_valid_nxt = 1'b0;
      unique case (r_state)
        S_FETCH: begin
          // With no request in flight there is nothing to drain.
          if (w_ack || !r_req) begin
            w_addr_nxt = w_branch_tgt;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
        S_HOLD: begin
          w_addr_nxt  = w_branch_tgt;
          w_state_nxt = S_FETCH;
        end
        S_DRAIN: begin
          if (w_ack) begin
            w_addr_nxt  = w_branch_tgt;
            w_state_nxt = S_FETCH;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_ack) begin
            w_pc_nxt   = w_pc_inc;
            w_addr_nxt = w_pc_inc;
            if (stall) begin
              w_skid_data_nxt = i_data;
              w_skid_pc4_nxt  = r_addr + 32'd4;
              w_state_nxt     = S_HOLD;
            end else begin
              w_instr_nxt = i_data;
              w_pc4_nxt   = r_addr + 32'd4;
              w_valid_nxt = 1'b1;
            end
          end else if (!stall) begin
            w_instr_nxt = BUBBLE_INSTR;
            w_valid_nxt = 1'b0;
          end
        end
        // Being in HOLD is what marks the skid buffer as occupied.
        S_HOLD: begin
          if (!stall) begin
            w_instr_nxt = r_skid_data;
            w_pc4_nxt   = r_skid_pc4;
            w_valid_nxt = 1'b1;
            w_addr_nxt  = r_pc;
            w_state_nxt = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (w_ack) begin
            w_addr_nxt  = r_pc;
            w_state_nxt = S_FETCH;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end

    w_req_nxt = (w_state_nxt != S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req       <= 1'b0;
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_instr     <= BUBBLE_INSTR;
      r_pc4       <= 32'd0;
      r_valid     <= 1'b0;
      r_skid_data <= 32'd0;
      r_skid_pc4  <= 32'd0;
    end else begin
      r_req       <= w_req_nxt;
      r_pc        <= w_pc_nxt;
      r_addr      <= w_addr_nxt;
      r_instr     <= w_instr_nxt;
      r_pc4       <= w_pc4_nxt;
      r_valid     <= w_valid_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_pc4  <= w_skid_pc4_nxt;
    end
  end

  assign i_addr      = r_addr;
  assign i_req       = r_req;
  assign instr       = r_instr;
  assign pc_plus_4   = r_pc4;
  assign instr_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_oldland_fetch.sv
// ---------------------------------------------------------------------------
// tb_oldland_fetch : directed + random bench for oldland_fetch against an
// instruction-stream model. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_oldland_fetch;

  localparam logic [31:0] BUBBLE = 32'hBADC0DE0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc = 32'd0;
  logic        i_ack = 1'b0;
  logic [31:0] i_data = 32'd0;
  logic [31:0] i_addr, instr, pc_plus_4;
  logic        i_req, instr_valid;

  logic [31:0] hi_addr, hi_instr, hi_pc4, hi_data;
  logic        hi_req, hi_valid;
  logic        hi_ack = 1'b1;
  logic        hi_stall = 1'b0;
  logic        hi_branch = 1'b0;
  logic [31:0] hi_bpc = 32'd0;

  int errors = 0;
  int checks = 0;

  // memory model state
  bit          tie_ack = 1'b0;
  int unsigned wmin = 0, wmax = 0, wcnt = 0;
  bit          pend = 1'b0;

  // instruction-stream model
  logic [31:0] exp_pc;
  int          delivered = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a >> 2;
  endfunction

  assign hi_data = memf(hi_addr);

  oldland_fetch #(.RESET_PC(32'h00000000), .BUBBLE_INSTR(BUBBLE)) dut (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_req(i_req), .i_ack(i_ack),
    .i_data(i_data), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .instr(instr), .pc_plus_4(pc_plus_4),
    .instr_valid(instr_valid)
  );

  oldland_fetch #(.RESET_PC(32'hFFFFFFFC), .BUBBLE_INSTR(BUBBLE)) dut_hi (
    .clk(clk), .rst_n(rst_n), .i_addr(hi_addr), .i_req(hi_req), .i_ack(hi_ack),
    .i_data(hi_data), .stall(hi_stall), .branch_taken(hi_branch),
    .branch_pc(hi_bpc), .instr(hi_instr), .pc_plus_4(hi_pc4),
    .instr_valid(hi_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers the request currently on the bus.
  task automatic mem_drive();
    if (tie_ack) begin
      i_ack  = 1'b1;
      i_data = memf(i_addr);
    end else if (!i_req) begin
      i_ack = 1'b0;
      pend  = 1'b0;
    end else begin
      if (!pend) begin
        pend = 1'b1;
        wcnt = $urandom_range(wmax, wmin);
      end
      if (wcnt == 0) begin
        i_ack  = 1'b1;
        i_data = memf(i_addr);
        pend   = 1'b0;
      end else begin
        i_ack  = 1'b0;
        i_data = $urandom;
        wcnt--;
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, check against the stream model.
  task automatic cycle(input logic st, input logic br, input logic [31:0] bpc);
    logic [31:0] p_addr, p_instr, p_pc4;
    logic        p_req, p_ack, p_valid;
    stall = st; branch_taken = br; branch_pc = bpc;
    mem_drive();
    p_addr = i_addr; p_req = i_req; p_ack = i_ack;
    p_instr = instr; p_pc4 = pc_plus_4; p_valid = instr_valid;
    @(posedge clk); #1;
    chk("addr_aligned", {30'd0, i_addr[1:0]}, 32'd0);
    if (p_req && !p_ack) begin
      chk("req_held", {31'd0, i_req}, 32'd1);
      chk("addr_stable", i_addr, p_addr);
    end
    if (br) begin
      chk("flush_valid", {31'd0, instr_valid}, 32'd0);
      chk("flush_instr", instr, BUBBLE);
      exp_pc = bpc & ~32'd3;
    end else if (st) begin
      chk("stall_instr", instr, p_instr);
      chk("stall_pc4", pc_plus_4, p_pc4);
      chk("stall_valid", {31'd0, instr_valid}, {31'd0, p_valid});
    end else if (instr_valid) begin
      chk("stream_instr", instr, memf(exp_pc));
      chk("stream_pc4", pc_plus_4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end else begin
      chk("bubble_instr", instr, BUBBLE);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; pend = 1'b0; i_ack = 1'b0;
    @(posedge clk); #1;
    chk("rst_addr", i_addr, 32'd0);
    chk("rst_req", {31'd0, i_req}, 32'd0);
    chk("rst_instr", instr, BUBBLE);
    chk("rst_pc4", pc_plus_4, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_hi_addr", hi_addr, 32'hFFFFFFFC);
    rst_n = 1'b1;
    exp_pc = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait memory with ack tied high
    tie_ack = 1'b1;
    do_reset();
    cycle(0, 0, 0);
    chk("zw_edge1_valid", {31'd0, instr_valid}, 32'd0);
    chk("zw_edge1_req", {31'd0, i_req}, 32'd1);
    cycle(0, 0, 0);
    chk("zw_first_instr", instr, 32'd0);
    chk("zw_first_pc4", pc_plus_4, 32'd4);
    chk("hi_first_valid", {31'd0, hi_valid}, 32'd1);
    chk("hi_first_pc4", hi_pc4, 32'd0);
    chk("hi_first_instr", hi_instr, 32'h3FFFFFFF);
    chk("hi_next_addr", hi_addr, 32'd0);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 0);
      chk("zw_no_bubble", {31'd0, instr_valid}, 32'd1);
    end

    // Stall for three cycles while 0x8 is being fetched
    do_reset();
    for (int k = 0; k < 3; k++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("hold_req_low", {31'd0, i_req}, 32'd0);
    chk("hold_instr", instr, 32'd1);
    chk("hold_pc4", pc_plus_4, 32'd8);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("release_instr", instr, 32'd2);
    chk("release_pc4", pc_plus_4, 32'd12);
    cycle(0, 0, 0);
    chk("after_release_instr", instr, 32'd3);

    // Two wait states: one valid followed by two bubbles
    tie_ack = 1'b0; wmin = 2; wmax = 2;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      cycle(0, 0, 0);
      chk("wait2_cadence", {31'd0, instr_valid}, {31'd0, (k >= 4 && k % 3 == 1)});
    end

    // Redirect while a 3-wait request to 0x10 is pending
    wmin = 3; wmax = 3;
    do_reset();
    for (int n = 0; n < 60 && !(i_req && i_addr == 32'h10); n++) cycle(0, 0, 0);
    chk("reach_0x10", i_addr, 32'h10);
    cycle(0, 1, 32'h100);
    chk("drain_addr_hold", i_addr, 32'h10);
    chk("drain_req", {31'd0, i_req}, 32'd1);
    for (int n = 0; n < 10 && i_addr == 32'h10; n++) cycle(0, 0, 0);
    chk("drain_next_addr", i_addr, 32'h100);
    for (int n = 0; n < 10 && !instr_valid; n++) cycle(0, 0, 0);
    chk("drain_first_pc4", pc_plus_4, 32'h104);
    chk("drain_first_instr", instr, 32'h40);

    // Redirect with stall high and the skid buffer full
    tie_ack = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 32'h203);
    chk("skidflush_addr", i_addr, 32'h200);
    chk("skidflush_req", {31'd0, i_req}, 32'd1);
    cycle(0, 0, 0);
    chk("skidflush_valid", {31'd0, instr_valid}, 32'd1);
    chk("skidflush_pc4", pc_plus_4, 32'h204);
    chk("skidflush_instr", instr, 32'h80);

    // Random waits, stalls and redirects against the stream model
    tie_ack = 1'b0; wmin = 0; wmax = 3;
    do_reset();
    delivered = 0;
    for (int k = 0; k < 400; k++) begin
      logic        st, br;
      logic [31:0] bpc;
      st  = ($urandom_range(0, 9) < 3);
      br  = ($urandom_range(0, 99) < 6);
      bpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF))
                                         : ($urandom & 32'h3FF);
      cycle(st, br, bpc);
    end
    chk("random_progress", {31'd0, (delivered > 40)}, 32'd1);

    // Asynchronous reset in the middle of a request
    wmin = 3; wmax = 3;
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("midreq_req_before", {31'd0, i_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, i_req}, 32'd0);
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_addr", i_addr, 32'd0);
    chk("async_rst_hi_req", {31'd0, hi_req}, 32'd0);
    chk("async_rst_hi_valid", {31'd0, hi_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/oldland_fetch.md
Name: oldland_fetch

Overview:
- Instruction fetch stage, directly upstream of oldland_decode.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents instr and pc_plus_4 to decode, with a valid flag, and inserts bubbles when memory is slow.
- Accepts a stall from downstream and a branch redirect from execute. Redirect flushes in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset (bits [1:0] must be 0)
BUBBLE_INSTR, 32'h00000000, instruction word driven to decode when instr_valid is 0

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
i_addr  output  32  instruction memory word address, byte-addressed, bits [1:0] always 0
i_req  output  1  read request, held until i_ack
i_ack  input  1  read complete; i_data valid this cycle; may be high the same cycle i_req rises
i_data  input  32  read data
stall  input  1  decode cannot accept a new instruction this cycle
branch_taken  input  1  one-cycle redirect pulse from execute
branch_pc  input  32  redirect target; bits [1:0] ignored, treated as 0
instr  output  32  instruction to decode (registered)
pc_plus_4  output  32  address of instr + 4 (registered)
instr_valid  output  1  instr/pc_plus_4 hold a real instruction

Behaviour:
- Reset (async assert, sync-safe release):
  - pc=RESET_PC, i_addr=RESET_PC, i_req=0, instr=BUBBLE_INSTR, pc_plus_4=0, instr_valid=0, skid buffer empty, state=FETCH.
  - i_req rises on the first clk edge after rst_n goes high.
- States:
  - FETCH: request outstanding, i_req=1.
  - HOLD: fetched word parked in the skid buffer because of stall, i_req=0.
  - DRAIN: a redirect arrived with a request outstanding; wait for i_ack, then discard the data, i_req=1.
- Request rules:
  - i_addr is registered.
  - i_addr and i_req stay stable from the cycle i_req rises until the cycle i_ack=1 inclusive.
  - A request is never abandoned.
  - At most one request is outstanding.
  - Back-to-back: a new request starts on the edge that completes the previous one. Zero-wait memory therefore sustains 1 instr/cycle.
- FETCH, i_ack=1, no stall, no branch:
  - instr<=i_data, pc_plus_4<=i_addr+4, instr_valid<=1.
  - pc<=pc+4, i_addr<=pc+4.
  - Stay in FETCH.
- FETCH, i_ack=1, stall=1: skid<=i_data (with its address); outputs hold; go to HOLD.
- FETCH, i_ack=0:
  - stall=0: instr<=BUBBLE_INSTR, instr_valid<=0, pc_plus_4 holds.
  - stall=1: all outputs hold.
- HOLD, stall=1: nothing changes.
- HOLD, stall=0: skid is moved to outputs (instr_valid<=1), i_addr<=pc, go to FETCH.
- stall is level-sensitive. The output registers change only when stall=0, or on a flush.
- branch_taken=1 has highest priority, regardless of stall or state. On that edge:
  - pc<=branch_pc & ~3.
  - instr<=BUBBLE_INSTR, instr_valid<=0.
  - Skid is invalidated.
- Next state after a redirect:
  - FETCH with i_ack=1 the same cycle: the data is dropped, i_addr<=new pc, stay in FETCH.
  - FETCH with i_ack=0: go to DRAIN; i_addr holds the old address.
  - HOLD: go to FETCH at new pc.
  - DRAIN: retarget pc only.
- DRAIN, i_ack=1: data discarded, i_addr<=pc, go to FETCH. While in DRAIN, instr_valid stays 0.
- Arithmetic: all adds are 32-bit modulo. pc 32'hFFFFFFFC increments to 32'h00000000, and its pc_plus_4 is 32'h00000000.
- Reset asserted mid-transaction: everything returns to reset values immediately. The memory must tolerate the dropped request.

Test Plan:
- Zero-wait memory (i_ack tied 1), RESET_PC=0, memory word n = n: after reset, instr_valid=1 from the 2nd edge. instr sequence 0,1,2,… with pc_plus_4 4,8,12,…, no bubbles.
- 2-wait-state memory: each instr_valid=1 cycle is followed by 2 bubbles. instr=BUBBLE_INSTR while instr_valid=0, and i_addr is stable across each request.
- Zero-wait memory, stall high 3 cycles while fetching 0x8:
  - Outputs frozen on the 0x4 word; i_req drops in HOLD.
  - After release the 0x8 word appears next, then 0xC.
  - No duplicates and no skips.
- Redirect with branch_pc=0x100 while a 3-wait request to 0x10 is pending:
  - DRAIN entered; the 0x10 data is never presented.
  - The next i_addr is 0x100, and the first valid pc_plus_4 is 0x104.
- Redirect with stall=1 and the skid buffer full: instr_valid drops to 0 next edge and the skid is discarded. With branch_pc=0x203, the fetch goes to 0x200.
- RESET_PC=32'hFFFFFFFC: the first instr has pc_plus_4=0, and the next i_addr is 0. Asserting rst_n=0 mid-request gives i_req=0 and instr_valid=0 immediately, without waiting for a clock edge.
